// File: rtl/clusterv_main_sram_arb.sv
// clusterv_main_sram_arb
// Round-robin arbiter that shares one single-port main SRAM (byte-enable
// target, 1-cycle read latency) between N_PORTS cluster requesters.
// It accepts at most one beat per cycle and supports locked multi-beat
// sequences. Each accepted beat gets a response on the next cycle.
//
// Ports
//   clock, reset   single clock, synchronous active-high reset
//   req_valid      per-port request valid
//   req_ready      per-port accept, one-hot or zero, same cycle as grant
//   req_lock       grantee keeps the grant after this beat
//   req_we         1 = write, 0 = read
//   req_addr       packed word addresses, port i at [i*ADR_WIDTH +: ADR_WIDTH]
//   req_byte_en    packed write byte enables
//   req_wdata      packed write data
//   rsp_valid      per-port response, one-hot or zero, one cycle after grant
//   rsp_rdata      read data for a read response, otherwise zero
//   t_addr, t_write_en, t_byte_en, t_write_data
//                  SRAM request, driven combinationally from the grantee
//   t_read_data    SRAM read data, valid the cycle after address issue
module clusterv_main_sram_arb #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned ADR_WIDTH = 10,
  parameter int unsigned DAT_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             req_valid,
  output logic [N_PORTS-1:0]             req_ready,
  input  logic [N_PORTS-1:0]             req_lock,
  input  logic [N_PORTS-1:0]             req_we,
  input  logic [N_PORTS*ADR_WIDTH-1:0]   req_addr,
  input  logic [N_PORTS*DAT_WIDTH/8-1:0] req_byte_en,
  input  logic [N_PORTS*DAT_WIDTH-1:0]   req_wdata,
  output logic [N_PORTS-1:0]             rsp_valid,
  output logic [DAT_WIDTH-1:0]           rsp_rdata,
  output logic [ADR_WIDTH-1:0]           t_addr,
  output logic                           t_write_en,
  output logic [DAT_WIDTH/8-1:0]         t_byte_en,
  output logic [DAT_WIDTH-1:0]           t_write_data,
  input  logic [DAT_WIDTH-1:0]           t_read_data
);

  localparam int unsigned BE_W  = DAT_WIDTH / 8;
  localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   lock_owner_q, lock_owner_d;
  logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_is_rd_q, rsp_is_rd_d;

  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [N_PORTS-1:0] gnt_oh;

  // Grant selection. Reset suppresses every grant so the SRAM port idles.
  always_comb begin
    int unsigned      cand;
    logic [PTR_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    if (!reset) begin
      if (state_q == ST_LOCKED) begin
        if (req_valid[lock_owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = lock_owner_q;
        end
      end else begin
        // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-two
        // port counts work.
        for (int unsigned k = 0; k < N_PORTS; k++) begin
          cand = 32'(rr_ptr_q) + k;
          if (cand >= N_PORTS) begin
            cand = cand - N_PORTS;
          end
          cand_idx = PTR_W'(cand);
          if (!gnt_any && req_valid[cand_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
          end
        end
      end
    end
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      gnt_oh[i] = gnt_any && (gnt_idx == PTR_W'(i));
    end
  end

  assign req_ready = gnt_oh;

  // SRAM request mux; reads always use full byte enables.
  always_comb begin
    t_addr       = '0;
    t_write_en   = 1'b0;
    t_byte_en    = '0;
    t_write_data = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (gnt_oh[i]) begin
        t_addr       = req_addr[i*ADR_WIDTH +: ADR_WIDTH];
        t_write_en   = req_we[i];
        t_byte_en    = req_we[i] ? req_byte_en[i*BE_W +: BE_W] : '1;
        t_write_data = req_wdata[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  // Next-state: pointer moves past every grantee; the lock flag of the
  // granted beat decides whether the grant is held.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    rsp_valid_d  = gnt_oh;
    rsp_is_rd_d  = gnt_any && !t_write_en;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(N_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (req_lock[gnt_idx]) begin
        state_d      = ST_LOCKED;
        lock_owner_d = gnt_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      rsp_valid_q  <= '0;
      rsp_is_rd_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_is_rd_q  <= rsp_is_rd_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_is_rd_q ? t_read_data : '0;

endmodule

// File: tb/tb_clusterv_main_sram_arb.sv
// Directed bench for clusterv_main_sram_arb with a behavioural 1024x32
// byte-enable SRAM (1-cycle read latency, write committed at the issue edge).
// Expected responses are queued when a beat is driven and popped one cycle
// later when the response is due.
module tb_clusterv_main_sram_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, req_lock, req_we, rsp_valid;
  logic [39:0] req_addr;
  logic [15:0] req_byte_en;
  logic [127:0] req_wdata;
  logic [31:0] rsp_rdata, t_write_data, t_read_data;
  logic [9:0]  t_addr;
  logic        t_write_en;
  logic [3:0]  t_byte_en;

  logic [9:0]  p_addr [4];
  logic [3:0]  p_be   [4];
  logic [31:0] p_wd   [4];

  logic        pl_fill, pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [1024];

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_addr[i*10 +: 10]   = p_addr[i];
      req_byte_en[i*4 +: 4]  = p_be[i];
      req_wdata[i*32 +: 32]  = p_wd[i];
    end
  end

  clusterv_main_sram_arb #(
    .N_PORTS  (4),
    .ADR_WIDTH(10),
    .DAT_WIDTH(32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_lock    (req_lock),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_byte_en (req_byte_en),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .t_addr      (t_addr),
    .t_write_en  (t_write_en),
    .t_byte_en   (t_byte_en),
    .t_write_data(t_write_data),
    .t_read_data (t_read_data)
  );

  function automatic logic [31:0] pat(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'h0, a};
  endfunction

  always @(posedge clock) begin
    if (pl_fill) begin
      for (int a = 0; a < 1024; a++) mem[a] <= pat(10'(a));
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (t_write_en) begin
      for (int b = 0; b < 4; b++)
        if (t_byte_en[b]) mem[t_addr][8*b +: 8] <= t_write_data[8*b +: 8];
    end
    t_read_data <= mem[t_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(e.vld));
      chk({tag, "_rsp_rdata"}, rsp_rdata, e.dat);
    end
  endtask

  // Checks the response due from the previous beat, drives this beat,
  // checks the grant and queues the response expected next cycle.
  task automatic issue(input logic [3:0] v, input logic [3:0] lk, input logic [3:0] we,
                       input logic [3:0] exp_gnt, input logic [31:0] exp_d, input string tag);
    exp_t e;
    check_rsp(tag);
    req_valid = v;
    req_lock  = lk;
    req_we    = we;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_gnt));
    e.vld = exp_gnt;
    e.dat = (exp_gnt != 4'b0 && (we & exp_gnt) == 4'b0) ? exp_d : 32'h0;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    check_rsp(tag);
    reset     = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    tick();
    reset = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_we = '0;
    pl_fill = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 4; i++) begin
      p_addr[i] = '0; p_be[i] = '0; p_wd[i] = '0;
    end
    tick();
    pl_fill = 1'b1; tick(); pl_fill = 1'b0;
    pl_en = 1'b1; pl_addr = 10'h012; pl_data = 32'hDEADBEEF; tick();
    pl_addr = 10'h3FF; pl_data = 32'hFFFFFFFF; tick();
    pl_en = 1'b0;

    // Reset state: all ports requesting writes, nothing may be granted.
    for (int i = 0; i < 4; i++) begin
      p_addr[i] = 10'h155; p_be[i] = 4'hF; p_wd[i] = 32'h1234_5678;
    end
    req_valid = 4'hF; req_we = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_t_we", 32'(t_write_en), 32'h0);
    chk("rst_t_addr", 32'(t_addr), 32'h0);
    chk("rst_t_be", 32'(t_byte_en), 32'h0);
    chk("rst_t_wdata", t_write_data, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    req_valid = '0; req_we = '0;
    reset = 1'b0;
    tick();

    // Single read from port 0.
    p_addr[0] = 10'h012;
    issue(4'b0001, 4'b0, 4'b0, 4'b0001, 32'hDEADBEEF, "t1_rd");
    chk("t1_t_addr", 32'(t_addr), 32'h012);
    chk("t1_t_be", 32'(t_byte_en), 32'hF);
    chk("t1_t_we", 32'(t_write_en), 32'h0);
    tick();
    issue(4'b0, 4'b0, 4'b0, 4'b0, 32'h0, "t1_idle");
    tick();

    // Partial byte write from port 2, then read back.
    p_addr[2] = 10'h3FF; p_be[2] = 4'b0101; p_wd[2] = 32'h11223344;
    issue(4'b0100, 4'b0, 4'b0100, 4'b0100, 32'h0, "t2_wr");
    chk("t2_t_we", 32'(t_write_en), 32'h1);
    chk("t2_t_be", 32'(t_byte_en), 32'h5);
    chk("t2_t_addr", 32'(t_addr), 32'h3FF);
    chk("t2_t_wdata", t_write_data, 32'h11223344);
    tick();
    issue(4'b0100, 4'b0, 4'b0, 4'b0100, 32'hFF22FF44, "t2_rd");
    chk("t2_rd_t_be", 32'(t_byte_en), 32'hF);
    tick();

    // Fairness: all ports requesting from reset.
    do_reset("t3_rst");
    for (int i = 0; i < 4; i++) p_addr[i] = 10'h040 + 10'(i);
    for (int c = 0; c < 8; c++) begin
      issue(4'hF, 4'b0, 4'b0, 4'b0001 << (c % 4), pat(10'h040 + 10'(c % 4)), "t3_rr");
      tick();
    end

    // Locked sequence from port 1 with ports 0 and 2 competing.
    p_addr[0] = 10'h070; p_addr[1] = 10'h061; p_addr[2] = 10'h072;
    issue(4'b0001, 4'b0,    4'b0, 4'b0001, pat(10'h070), "t4_pre");  tick();
    issue(4'b0111, 4'b0010, 4'b0, 4'b0010, pat(10'h061), "t4_lk1");  tick();
    issue(4'b0101, 4'b0010, 4'b0, 4'b0000, 32'h0,        "t4_gap");  tick();
    issue(4'b0111, 4'b0010, 4'b0, 4'b0010, pat(10'h061), "t4_lk2");  tick();
    issue(4'b0111, 4'b0000, 4'b0, 4'b0010, pat(10'h061), "t4_lk3");  tick();
    issue(4'b0101, 4'b0,    4'b0, 4'b0100, pat(10'h072), "t4_p2");   tick();
    issue(4'b0001, 4'b0,    4'b0, 4'b0001, pat(10'h070), "t4_p0");   tick();

    // Read-after-write on consecutive cycles.
    p_addr[3] = 10'h100; p_wd[3] = 32'hA5A5A5A5; p_be[3] = 4'hF;
    p_addr[0] = 10'h100;
    issue(4'b1000, 4'b0, 4'b1000, 4'b1000, 32'h0, "t5_wr");          tick();
    issue(4'b0001, 4'b0, 4'b0, 4'b0001, 32'hA5A5A5A5, "t5_raw");     tick();

    // Reset while port 1 holds a lock with a read outstanding.
    p_addr[1] = 10'h050; p_addr[0] = 10'h030; p_addr[2] = 10'h072;
    issue(4'b0010, 4'b0010, 4'b0, 4'b0010, pat(10'h050), "t6_lock"); tick();
    check_rsp("t6_pre");
    reset = 1'b1; req_valid = 4'b0111; req_lock = 4'b0010;
    #1;
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    tick();
    reset = 1'b0;
    chk("t6_rsp_drop", 32'(rsp_valid), 32'h0);
    issue(4'b0111, 4'b0010, 4'b0, 4'b0001, pat(10'h030), "t6_after"); tick();
    issue(4'b0, 4'b0, 4'b0, 4'b0, 32'h0, "drain");                    tick();
    check_rsp("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
